// File: rtl/turn_signal_seq_if.sv
// turn_signal_seq_if: switch inputs and lamp/mode outputs of the
// turn-signal controller, with driver (master) and controller (slave) views.
interface turn_signal_seq_if #(
   parameter int LAMPS = 3
);
   logic l;
   logic r;
   logic halt;
   logic fault_in;
   logic [2*LAMPS-1:0] led;
   logic [2:0] mode;

   modport master (
      output l, r, halt, fault_in,
      input  led, mode
   );

   modport slave (
      input  l, r, halt, fault_in,
      output led, mode
   );
endinterface

// File: rtl/turn_signal_seq.sv
// turn_signal_seq: sequential turn-signal / hazard / fault-flash lamp controller.
// Optional latched turn requests: define TSC_TURN_LATCH_EN.
module turn_signal_seq #(
   parameter int LAMPS = 3,
   parameter int DIV   = 25_000_000,
   parameter int BURST = 20
) (
   input  logic clk,
   input  logic rst,
   turn_signal_seq_if.slave bus
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = $clog2(LAMPS + 1);
   localparam int BW = $clog2(BURST + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LEFT    = 3'd1,
      RIGHT   = 3'd2,
      HAZ_ON  = 3'd3,
      HAZ_OFF = 3'd4,
      FAULT   = 3'd5
   } state_t;

   state_t state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_inc;
   logic [BW-1:0] bcnt;
   logic [2*LAMPS-1:0] led_q;
   logic step;
   logic lq;
   logic rq;
   logic haz;
   logic sweeping;
   logic held;

   // Lamp pattern for a sweep: n lamps lit from the innermost one outward.
   function automatic logic [2*LAMPS-1:0] sweep_led(input logic left,
                                                    input logic [IW-1:0] n);
      logic [2*LAMPS-1:0] v;
      v = '1;
      for (int i = 0; i < LAMPS; i++) begin
         if (i < int'(n)) begin
            if (left) v[LAMPS+i] = 1'b0;
            else      v[LAMPS-1-i] = 1'b0;
         end
      end
      return v;
   endfunction

`ifdef TSC_TURN_LATCH_EN
   logic l_q;
   logic r_q;
   logic left_req;
   logic right_req;
   logic rise_l;
   logic rise_r;

   assign rise_l = bus.l & ~l_q;
   assign rise_r = bus.r & ~r_q;

   // Rising switch edges toggle one side's request and cancel the other.
   always_ff @(posedge clk) begin
      if (rst) begin
         l_q       <= 1'b0;
         r_q       <= 1'b0;
         left_req  <= 1'b0;
         right_req <= 1'b0;
      end else begin
         l_q <= bus.l;
         r_q <= bus.r;
         if (rise_l && rise_r) begin
            left_req  <= 1'b0;
            right_req <= 1'b0;
         end else if (rise_l) begin
            left_req  <= ~left_req;
            right_req <= 1'b0;
         end else if (rise_r) begin
            right_req <= ~right_req;
            left_req  <= 1'b0;
         end
      end
   end

   assign lq = left_req;
   assign rq = right_req;
`else
   assign lq = bus.l;
   assign rq = bus.r;
`endif

   assign step     = (cnt == CW'(DIV - 1));
   assign haz      = bus.halt | (bus.l & bus.r);
   assign idx_inc  = idx + 1'b1;
   assign sweeping = (state == LEFT) || (state == RIGHT);
   assign held     = (state == LEFT) ? (lq & ~rq) : (rq & ~lq);

   // Step prescaler: one-cycle strobe every DIV clocks.
   always_ff @(posedge clk) begin
      if (rst)       cnt <= '0;
      else if (step) cnt <= '0;
      else           cnt <= cnt + 1'b1;
   end

   // Step-driven sequencer; lamp drive is registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         bcnt  <= '0;
         led_q <= '1;
      end else if (step) begin
         if (state == FAULT) begin
            if (bcnt == BW'(BURST)) begin
               state <= IDLE;
               bcnt  <= '0;
               led_q <= '1;
            end else begin
               bcnt  <= bcnt + 1'b1;
               led_q <= bcnt[0] ? '1 : '0;
            end
         end else if (bus.fault_in) begin
            state <= FAULT;
            bcnt  <= BW'(1);
            idx   <= '0;
            led_q <= '0;
         end else if (haz) begin
            state <= (state == HAZ_ON) ? HAZ_OFF : HAZ_ON;
            idx   <= '0;
            led_q <= (state == HAZ_ON) ? '1 : '0;
         end else if (sweeping && held && (idx < IW'(LAMPS))) begin
            idx   <= idx_inc;
            led_q <= sweep_led(state == LEFT, idx_inc);
         end else if ((state == IDLE) && lq) begin
            state <= LEFT;
            idx   <= IW'(1);
            led_q <= sweep_led(1'b1, IW'(1));
         end else if ((state == IDLE) && rq) begin
            state <= RIGHT;
            idx   <= IW'(1);
            led_q <= sweep_led(1'b0, IW'(1));
         end else begin
            state <= IDLE;
            idx   <= '0;
            led_q <= '1;
         end
      end
   end

   assign bus.led  = led_q;
   assign bus.mode = state;
endmodule

// File: tb/tb_turn_signal_seq.sv
// tb_turn_signal_seq: randomized scoreboard bench for turn_signal_seq
// against a step-level behavioural model (LAMPS=3, DIV=4, BURST=6).
module tb_turn_signal_seq;
   localparam int L  = 3;
   localparam int DV = 4;
   localparam int BU = 6;

   typedef struct packed {
      logic [2*L-1:0] led;
      logic [2:0]     mode;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   turn_signal_seq_if #(.LAMPS(L)) bus ();

   turn_signal_seq #(
      .LAMPS(L),
      .DIV(DV),
      .BURST(BU)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   pc     = 0;

   // behavioural model: mode code, lamps lit in sweep, burst step number
   int m_mode = 0;
   int m_n    = 0;
   int m_b    = 0;

   function automatic exp_t model_out();
      exp_t e;
      logic [2*L-1:0] mask;
      mask = '0;
      if (m_mode == 1) mask = 6'(((1 << m_n) - 1) << L);
      if (m_mode == 2) mask = 6'(((1 << m_n) - 1) << (L - m_n));
      if (m_mode == 3) mask = '1;
      if (m_mode == 5 && (m_b % 2) == 1) mask = '1;
      e.led  = ~mask;
      e.mode = 3'(m_mode);
      return e;
   endfunction

   task automatic model_step(input logic il, ir, ih, ifa);
      logic hz;
      logic want;
      hz = ih | (il & ir);
      if (m_mode == 5) begin
         if (m_b == BU) begin
            m_mode = 0;
            m_b    = 0;
         end else begin
            m_b = m_b + 1;
         end
      end else if (ifa) begin
         m_mode = 5;
         m_b    = 1;
         m_n    = 0;
      end else if (hz) begin
         m_mode = (m_mode == 3) ? 4 : 3;
         m_n    = 0;
      end else if (m_mode == 1 || m_mode == 2) begin
         want = (m_mode == 1) ? (il & ~ir) : (ir & ~il);
         if (want && m_n < L) m_n = m_n + 1;
         else begin
            m_mode = 0;
            m_n    = 0;
         end
      end else if (m_mode == 0 && il) begin
         m_mode = 1;
         m_n    = 1;
      end else if (m_mode == 0 && ir) begin
         m_mode = 2;
         m_n    = 1;
      end else begin
         m_mode = 0;
         m_n    = 0;
      end
   endtask

   task automatic check(input string nm, input exp_t e);
      n_chk++;
      if (bus.led === e.led && bus.mode === e.mode) n_pass++;
      else $display("FAIL %s t=%0t led=%b mode=%0d required led=%b mode=%0d",
                    nm, $time, bus.led, bus.mode, e.led, e.mode);
   endtask

   // one clock of stimulus; expectations are queued for edges that move outputs
   task automatic drive_cycle(input logic il, ir, ih, ifa, irs);
      @(negedge clk);
      bus.l        = il;
      bus.r        = ir;
      bus.halt     = ih;
      bus.fault_in = ifa;
      rst          = irs;
      if (irs) begin
         m_mode = 0;
         m_n    = 0;
         m_b    = 0;
         q.push_back(model_out());
      end else if (pc == DV - 1) begin
         model_step(il, ir, ih, ifa);
         q.push_back(model_out());
      end
      @(posedge clk);
      if (irs || pc == DV - 1) pc = 0;
      else pc = pc + 1;
   endtask

   task automatic hold(input logic il, ir, ih, ifa, input int cyc);
      for (int i = 0; i < cyc; i++) drive_cycle(il, ir, ih, ifa, 1'b0);
   endtask

   task automatic to_step_cycle();
      for (int i = 0; i < DV && pc != DV - 1; i++)
         drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // monitor: pops after every output-moving edge, otherwise checks hold
   initial begin : monitor
      exp_t cur;
      bit   started;
      started = 0;
      cur     = '0;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            cur     = q.pop_front();
            started = 1;
            check("step", cur);
         end else if (started) begin
            check("hold", cur);
         end
      end
   end

   initial begin : driver
      int sel;
      int len;
      bus.l        = 1'b0;
      bus.r        = 1'b0;
      bus.halt     = 1'b0;
      bus.fault_in = 1'b0;
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      hold(1'b1, 1'b0, 1'b0, 1'b0, DV * 6);
      hold(1'b0, 1'b0, 1'b0, 1'b0, DV * 2);
      to_step_cycle();
      hold(1'b0, 1'b1, 1'b0, 1'b0, DV * 2);
      hold(1'b0, 1'b0, 1'b0, 1'b0, DV * 2);
      to_step_cycle();
      hold(1'b1, 1'b0, 1'b0, 1'b0, DV * 2);
      hold(1'b1, 1'b0, 1'b1, 1'b0, DV * 4);
      hold(1'b0, 1'b0, 1'b0, 1'b0, DV * 2);
      to_step_cycle();
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(1'b0, 1'b0, 1'b0, 1'b0, DV * 2);
      to_step_cycle();
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(1'b1, 1'b1, 1'b1, 1'b0, DV * 6);
      to_step_cycle();
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(1'b0, 1'b0, 1'b0, 1'b0, DV + 1);
      if (pc == DV - 1) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      hold(1'b0, 1'b0, 1'b0, 1'b0, DV * 3);
      for (int s = 0; s < 300; s++) begin
         sel = $urandom_range(99);
         len = $urandom_range(30, 1);
         if (sel < 30)      hold(1'b1, 1'b0, 1'b0, 1'b0, len);
         else if (sel < 55) hold(1'b0, 1'b1, 1'b0, 1'b0, len);
         else if (sel < 65) hold(1'(sel), 1'b0, 1'b1, 1'b0, len);
         else if (sel < 70) hold(1'b1, 1'b1, 1'b0, 1'b0, len);
         else if (sel < 76) hold(1'(sel), 1'(sel >> 1), 1'b0, 1'b1,
                                 $urandom_range(DV * 2, 1));
         else if (sel < 78) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         else               hold(1'b0, 1'b0, 1'b0, 1'b0, len);
      end
      hold(1'b0, 1'b0, 1'b0, 1'b0, DV * 2);
      @(negedge clk);
      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain pending=%0d required 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
